// File: rtl/clock_glitch_gen.sv
// Clock generator with programmable half period and injected phase inversions
// (glitches), raised either automatically every N base periods or on a trigger.
module clock_glitch_gen #(
    parameter int HP_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic             main_clock,
    input  logic             main_reset,
    input  logic             enable,
    input  logic [HP_W-1:0]  half_period,
    input  logic [CNT_W-1:0] glitch_interval,
    input  logic [3:0]       glitch_width,
    input  logic             trigger,
    output logic             noisy_clk,
    output logic             glitch_active,
    output logic [CNT_W-1:0] glitch_count
);

    typedef enum logic [1:0] {IDLE, RUN, GLITCH} state_e;

    state_e           state_q, state_d;
    logic [HP_W-1:0]  hp_q, hp_d, phase_q, phase_d;
    logic [CNT_W-1:0] gi_q, gi_d, period_q, period_d, gcnt_q, gcnt_d;
    logic [3:0]       gw_q, gw_d, glen_q, glen_d;
    logic             base_q, base_d, pend_q, pend_d;
    logic             active_q, active_d, noisy_q, noisy_d;

    logic             tog, rise, auto_req, start, glen_done;
    logic [CNT_W-1:0] period_inc;

    assign tog        = (phase_q == hp_q - HP_W'(1));
    assign rise       = tog && !base_q;
    assign period_inc = period_q + CNT_W'(1);
    assign auto_req   = rise && (gi_q != '0) && (period_inc == gi_q);
    assign start      = (state_q == RUN) && (auto_req || pend_q);
    assign glen_done  = (glen_q == gw_q - 4'd1);

    // State register
    // NOTE: every flop, including the parameter snapshots, is cleared by the
    // asynchronous reset so outputs drop without needing a clock edge.
    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic; losing enable outranks every other transition.
    // NOTE: state_d is given a default first so no path through the case
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
                     else if (start) state_d = GLITCH;
            GLITCH:  if (!enable) state_d = IDLE;
                     else if (glen_done) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: snapshot, base divider, period counter, requests
    always_comb begin
        hp_d     = hp_q;
        gi_d     = gi_q;
        gw_d     = gw_q;
        phase_d  = phase_q;
        period_d = period_q;
        base_d   = base_q;
        pend_d   = pend_q;
        gcnt_d   = gcnt_q;
        glen_d   = glen_q;
        if (state_q == IDLE) begin
            if (enable) begin
                hp_d     = (half_period == '0) ? HP_W'(1) : half_period;
                gi_d     = glitch_interval;
                gw_d     = (glitch_width == 4'd0) ? 4'd1 : glitch_width;
                phase_d  = '0;
                period_d = '0;
                base_d   = 1'b0;
                pend_d   = 1'b0;
                gcnt_d   = '0;
                glen_d   = '0;
            end
        end else if (!enable) begin
            phase_d  = '0;
            period_d = '0;
            base_d   = 1'b0;
            pend_d   = 1'b0;
            glen_d   = '0;
        end else begin
            phase_d = tog ? '0 : phase_q + HP_W'(1);
            base_d  = base_q ^ tog;
            if (rise) period_d = auto_req ? '0 : period_inc;
            if (state_q == GLITCH) begin
                pend_d = pend_q | trigger | auto_req;
                glen_d = glen_q + 4'd1;
            end else if (start) begin
                // This cycle's trigger is a fresh request, not the one being served
                pend_d = trigger;
                glen_d = '0;
                if (gcnt_q != '1) gcnt_d = gcnt_q + CNT_W'(1);
            end else begin
                pend_d = pend_q | trigger;
            end
        end
    end

    // Output logic: registered from next-state values so noisy_clk lines up
    // exactly with the base flop and glitch_active.
    always_comb begin
        active_d = (state_d == GLITCH);
        noisy_d  = base_d ^ active_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values computed above.
    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            hp_q     <= '0;
            gi_q     <= '0;
            gw_q     <= '0;
            phase_q  <= '0;
            period_q <= '0;
            base_q   <= 1'b0;
            pend_q   <= 1'b0;
            gcnt_q   <= '0;
            glen_q   <= '0;
            active_q <= 1'b0;
            noisy_q  <= 1'b0;
        end else begin
            hp_q     <= hp_d;
            gi_q     <= gi_d;
            gw_q     <= gw_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            base_q   <= base_d;
            pend_q   <= pend_d;
            gcnt_q   <= gcnt_d;
            glen_q   <= glen_d;
            active_q <= active_d;
            noisy_q  <= noisy_d;
        end
    end

    assign noisy_clk     = noisy_q;
    assign glitch_active = active_q;
    assign glitch_count  = gcnt_q;

endmodule

// File: tb/tb_clock_glitch_gen.sv
// Self-checking bench: directed scenarios plus random stimulus against an
// arithmetic model of the generated clock and glitch schedule.
module tb_clock_glitch_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, trig;
    logic [7:0] hp, gi;
    logic [3:0] gw;
    logic       noisy, ga, noisy2, ga2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state after the most recent rising edge
    int m_run, m_k, m_hp, m_gi, m_gw, m_pend, m_left, m_count, m_cmp2;
    int m_base, m_ga, m_noisy;

    always #5 clk = ~clk;

    clock_glitch_gen #(.HP_W(8), .CNT_W(8)) dut (
        .main_clock(clk), .main_reset(rst_n), .enable(en),
        .half_period(hp), .glitch_interval(gi), .glitch_width(gw),
        .trigger(trig), .noisy_clk(noisy), .glitch_active(ga),
        .glitch_count(cnt)
    );

    clock_glitch_gen #(.HP_W(8), .CNT_W(2)) dut2 (
        .main_clock(clk), .main_reset(rst_n), .enable(en),
        .half_period(hp), .glitch_interval(gi[1:0]), .glitch_width(gw),
        .trigger(trig), .noisy_clk(noisy2), .glitch_active(ga2),
        .glitch_count(cnt2)
    );

    task automatic check(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_k = 0; m_hp = 1; m_gi = 0; m_gw = 1;
        m_pend = 0; m_left = 0; m_count = 0; m_cmp2 = 1;
        m_base = 0; m_ga = 0; m_noisy = 0;
    endtask

    // Base clock is (k / hp) mod 2 where k counts edges since entering RUN;
    // the n-th rising toggle happens at k = hp + (n-1)*2*hp.
    task automatic model_edge();
        int kn, per, auto_r;
        if (m_run == 0) begin
            if (en) begin
                m_run = 1; m_k = 0; m_pend = 0; m_left = 0; m_count = 0;
                m_hp = (hp == 0) ? 1 : int'(hp);
                m_gi = int'(gi);
                m_gw = (gw == 0) ? 1 : int'(gw);
                m_cmp2 = (gi == 0);
            end
        end else if (!en) begin
            m_run = 0; m_k = 0; m_pend = 0; m_left = 0;
        end else begin
            kn = m_k + 1;
            per = 2 * m_hp;
            auto_r = (m_gi != 0) && (kn % per == m_hp) && (((kn / per) + 1) % m_gi == 0);
            if (m_left > 0) begin
                m_left--;
                m_pend = (m_pend != 0 || trig || auto_r != 0) ? 1 : 0;
            end else if (auto_r != 0 || m_pend != 0) begin
                m_left = m_gw;
                m_count++;
                m_pend = int'(trig);
            end else begin
                m_pend = int'(trig);
            end
            m_k = kn;
        end
        m_base  = (m_run != 0) ? (m_k / m_hp) % 2 : 0;
        m_ga    = (m_left > 0) ? 1 : 0;
        m_noisy = m_base ^ m_ga;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("noisy_clk", int'(noisy), m_noisy);
        check("glitch_active", int'(ga), m_ga);
        check("glitch_count", int'(cnt), sat(m_count, 255));
        if (m_cmp2 != 0) begin
            check("active_w2", int'(ga2), m_ga);
            check("count_w2", int'(cnt2), sat(m_count, 3));
        end
    endtask

    task automatic go_idle();
        en = 1'b0; trig = 1'b0;
        tick();
    endtask

    initial begin
        int hi_cnt, seen;
        rst_n = 1'b0; en = 1'b0; trig = 1'b0; hp = 8'd0; gi = 8'd0; gw = 4'd0;
        model_reset();
        #12;
        check("reset_noisy", int'(noisy), 0);
        check("reset_active", int'(ga), 0);
        check("reset_count", int'(cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Plain clock, no glitches, 50 periods
        hp = 8'd5; gi = 8'd0; gw = 4'd3; en = 1'b1;
        repeat (501) tick();
        check("plain_count", int'(cnt), 0);

        // Auto glitch every 3rd period
        go_idle();
        hp = 8'd5; gi = 8'd3; gw = 4'd2; en = 1'b1;
        tick();
        repeat (90) tick();
        check("auto_count_9p", int'(cnt), 3);

        // Two triggered 8-cycle glitches, second requested mid-glitch
        go_idle();
        hp = 8'd5; gi = 8'd0; gw = 4'd8; en = 1'b1;
        tick();
        hi_cnt = 0;
        trig = 1'b1; tick(); trig = 1'b0;
        repeat (4) begin tick(); hi_cnt += int'(ga); end
        trig = 1'b1; tick(); hi_cnt += int'(ga); trig = 1'b0;
        repeat (25) begin tick(); hi_cnt += int'(ga); end
        check("trig_active_cycles", hi_cnt, 16);
        check("trig_count", int'(cnt), 2);

        // Minimum half period and width, saturation on the 2-bit counter
        go_idle();
        hp = 8'd0; gi = 8'd0; gw = 4'd0; en = 1'b1;
        tick();
        repeat (5) begin
            trig = 1'b1; tick(); trig = 1'b0;
            repeat (3) tick();
        end
        check("min_count", int'(cnt), 5);
        check("sat_count_w2", int'(cnt2), 3);

        // Asynchronous reset mid-run with a nonzero count
        #1 rst_n = 1'b0;
        #1;
        check("async_noisy", int'(noisy), 0);
        check("async_active", int'(ga), 0);
        check("async_count", int'(cnt), 0);
        rst_n = 1'b1;
        model_reset();
        tick();

        // Enable dropped mid-glitch, then re-enabled
        hp = 8'd5; gi = 8'd0; gw = 4'd8; en = 1'b1;
        tick();
        trig = 1'b1; tick(); trig = 1'b0;
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            tick();
            if (ga) seen = 1;
        end
        check("wait_glitch", seen, 1);
        tick();
        en = 1'b0; tick();
        check("drop_noisy", int'(noisy), 0);
        check("drop_active", int'(ga), 0);
        check("drop_count_held", int'(cnt), 1);
        en = 1'b1; tick();
        check("reenable_count", int'(cnt), 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) check("reenable_pre_rise", int'(noisy), 0);
            if (i == 5) check("reenable_rise", int'(noisy), 1);
        end

        // Random stimulus; parameter changes while running must be ignored
        for (int i = 0; i < 4000; i++) begin
            en   = ($urandom_range(0, 199) != 0);
            trig = ($urandom_range(0, 24) == 0);
            hp   = 8'($urandom_range(0, 6));
            gi   = 8'($urandom_range(0, 3));
            gw   = 4'($urandom_range(0, 9));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_glitch_gen.md
CLOCK_GLITCH_GEN -- requirements
Module: clock_glitch_gen

Interface
REQ-001 Parameter HP_W, default 8: width of half_period and of the internal half-period counter.
REQ-002 Parameter CNT_W, default 8: width of glitch_interval, the period counter and glitch_count.
REQ-003 Port main_clock  input  1: single clock; all state updates on its rising edge.
REQ-004 Port main_reset  input  1: asynchronous, active-low reset.
REQ-005 Port enable  input  1: 1 = generate the clock, 0 = idle.
REQ-006 Port half_period  input  HP_W: high/low phase length in main_clock cycles; value 0 is treated as 1.
REQ-007 Port glitch_interval  input  CNT_W: number of base periods between automatic glitches; 0 = automatic glitches off.
REQ-008 Port glitch_width  input  4: inversion length in main_clock cycles; value 0 is treated as 1.
REQ-009 Port trigger  input  1: one-cycle request for a single glitch.
REQ-010 Port noisy_clk  output  1: generated clock with injected inversions, driven from a flop.
REQ-011 Port glitch_active  output  1: high during every cycle in which noisy_clk is inverted.
REQ-012 Port glitch_count  output  CNT_W: number of glitches injected, saturating.

Function
REQ-013 FSM states: IDLE, RUN, GLITCH.
REQ-014 Transitions:
- IDLE->RUN on enable=1.
- RUN->GLITCH on a glitch start.
- GLITCH->RUN after glitch_width cycles.
- RUN or GLITCH->IDLE on enable=0, taking priority over every other transition.
REQ-015 On IDLE->RUN the block snapshots half_period, glitch_interval and glitch_width, then clears the base flop, all counters, the trigger pending flag and glitch_count.
- Input changes while running are ignored until the next IDLE->RUN.
REQ-016 Base clock: in RUN and GLITCH the phase counter increments every cycle.
- At hp-1 the base flop toggles and the counter returns to 0.
- Base period = 2*hp cycles, 50% duty; the first rising toggle occurs hp cycles after entering RUN.
REQ-017 Period counter: increments on each base 0->1 toggle.
- When it equals a nonzero glitch_interval it clears and raises an auto request in that cycle.
- Requests raised in GLITCH are still counted.
REQ-018 Trigger: trigger=1 in RUN or GLITCH sets a pending flag.
- trigger in IDLE is ignored.
REQ-019 Glitch start: in RUN, if an auto request or the pending flag is present, the glitch starts on the next edge.
- glitch_active goes to 1 for exactly glitch_width cycles.
- The pending flag clears and glitch_count increments by 1.
REQ-020 Simultaneous auto request and pending trigger produce one glitch and one count, and both requests clear.
REQ-021 A request raised during GLITCH is held pending and starts a new glitch on the edge after glitch_active falls, with at least one RUN cycle between glitches.
- A second auto request while one is already pending is merged.
REQ-022 noisy_clk = base XOR glitch_active, registered, so it has zero added latency relative to both of those flops.
- The base clock keeps running through a glitch.
- A glitch spanning a base toggle stays inverted across the toggle.
REQ-023 glitch_count saturates at 2^CNT_W-1 and holds.
- It holds its value in IDLE and clears only on reset or IDLE->RUN.
REQ-024 In IDLE: noisy_clk=0, glitch_active=0, counters frozen at 0.
- enable=0 mid-glitch forces noisy_clk=0 and glitch_active=0 on the next edge, and clears pending.

Reset
REQ-025 main_reset=0 immediately forces the FSM to IDLE and all of the following to 0, independent of main_clock:
- noisy_clk, glitch_active, glitch_count;
- base flop, phase counter, period counter, pending flag.
REQ-026 After main_reset rises, the first state change occurs on the first main_clock rising edge with enable=1.

Verification
REQ-027 Assert main_reset=0 mid-RUN with glitch_count=5 -> all outputs 0 within the same cycle, with no clock edge required.
REQ-028 half_period=5, glitch_interval=0, enable=1 -> noisy_clk period 10 cycles, high 5 / low 5, glitch_active never 1, glitch_count stays 0 over 50 periods.
REQ-029 half_period=5, glitch_interval=3, glitch_width=2 -> on every 3rd rising base toggle noisy_clk is low for 2 cycles instead of high; glitch_count=3 after 9 periods.
REQ-030 half_period=5, glitch_width=8, trigger pulsed twice (second pulse while glitch_active=1) -> two 8-cycle glitches separated by exactly one uninverted cycle; glitch_count=2.
REQ-031 half_period=0, glitch_width=0, trigger pulse -> noisy_clk toggles every cycle and the glitch lasts 1 cycle; CNT_W=2 with 5 triggers -> glitch_count saturates at 3.
REQ-032 enable dropped during a glitch -> next edge noisy_clk=0, glitch_active=0, glitch_count held; enable reasserted -> glitch_count=0, first rising noisy_clk edge hp cycles later.
